watch_set_ctrl: RTL and testbench

Front-panel controller for the watch, directly upstream of the date/time counter. It synchronises and debounces three raw push-buttons (mode, up, down) and runs the set-mode state machine. It emits the one-cycle increment/decrement strobes the counter consumes (i_y … d_s) and gives the display stage the field under edit and a blink enable. Runs on the same 1 kHz clk as the counter, so 1 cycle = 1 ms.

---
 rtl/watch_pkg.sv | 34 +++
 rtl/watch_debounce.sv | 43 ++++
 rtl/watch_set_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch front panel: the field/state code seen by
// the display stage, and default timing constants in 1 ms clock cycles.
package watch_pkg;

  typedef enum logic [2:0] {
    F_NORMAL = 3'd0,
    F_YEAR   = 3'd1,
    F_MONTH  = 3'd2,
    F_DAY    = 3'd3,
    F_AP     = 3'd4,
    F_HOUR   = 3'd5,
    F_MIN    = 3'd6,
    F_SEC    = 3'd7
  } field_e;

  localparam int DEB_MS_DEF     = 20;
  localparam int TIMEOUT_MS_DEF = 10000;
  localparam int BLINK_MS_DEF   = 250;

  // Mode-button sequence: NORMAL -> YEAR -> ... -> SEC -> NORMAL.
  function automatic field_e next_field(input field_e f);
    case (f)
      F_NORMAL: return F_YEAR;
      F_YEAR:   return F_MONTH;
      F_MONTH:  return F_DAY;
      F_DAY:    return F_AP;
      F_AP:     return F_HOUR;
      F_HOUR:   return F_MIN;
      F_MIN:    return F_SEC;
      default:  return F_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/watch_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter, and a one-cycle
// press pulse on the 0->1 change of the debounced level.
module watch_debounce
  import watch_pkg::*;
#(
  parameter int DEB_MS = DEB_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronise, then accept the new level after DEB_MS cycles of disagreement.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_MS - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch set-mode controller: debounces mode/up/down, walks the set-mode
// state machine, issues single-cycle inc/dec strobes to the date/time counter
// and drives the edit/field/blink display controls.
// Optional feature: define WATCH_AUTOREPEAT_EN for held-button auto-repeat.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int DEB_MS     = DEB_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int BLINK_MS   = BLINK_MS_DEF
`ifdef WATCH_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       i_y,
  output logic       i_mo,
  output logic       i_d,
  output logic       i_a,
  output logic       i_h,
  output logic       i_m,
  output logic       i_s,
  output logic       d_y,
  output logic       d_mo,
  output logic       d_d,
  output logic       d_h,
  output logic       d_m,
  output logic       d_s,
  output logic       edit,
  output logic [2:0] field,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  logic mode_l, up_l, down_l;
  logic mode_p, up_p, down_p;
  logic unused_levels;

  watch_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_l), .press(mode_p));
  watch_debounce #(.DEB_MS(DEB_MS)) u_deb_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(up_l), .press(up_p));
  watch_debounce #(.DEB_MS(DEB_MS)) u_deb_down (
    .clk(clk), .rst(rst), .raw(btn_down), .level(down_l), .press(down_p));

  field_e        state, state_nxt;
  logic [6:0]    inc_q, inc_nxt;   // y, mo, d, a, h, m, s
  logic [5:0]    dec_q, dec_nxt;   // y, mo, d, h, m, s
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;
  logic          go_up, go_dn, strobe, entry, timeout;

`ifdef WATCH_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rep_act, rep_up, rep_first, held, rep_fire;
  logic [RW-1:0] rep_cnt, rep_lim;

  assign held     = rep_up ? up_l : down_l;
  assign rep_lim  = rep_first ? RW'(REPEAT_DELAY_MS - 1) : RW'(REPEAT_RATE_MS - 1);
  assign rep_fire = rep_act && held && (rep_cnt == rep_lim) && !mode_p && !up_p && !down_p;
  assign unused_levels = mode_l;
`else
  assign unused_levels = ^{mode_l, up_l, down_l};
`endif

  // Next state and strobe decode; timeout beats mode, mode beats up/down.
  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    inc_nxt   = '0;
    dec_nxt   = '0;
    go_up     = 1'b0;
    go_dn     = 1'b0;
    timeout   = (state != F_NORMAL) && (tmo_cnt == TW'(TIMEOUT_MS));
    if (timeout) begin
      state_nxt = F_NORMAL;
    end else if (mode_p) begin
      state_nxt = next_field(state);
    end else if (up_p && !down_p && state != F_NORMAL) begin
      go_up = 1'b1;
    end else if (down_p && !up_p && state != F_NORMAL) begin
      go_dn = 1'b1;
`ifdef WATCH_AUTOREPEAT_EN
    end else if (rep_fire) begin
      go_up = rep_up;
      go_dn = !rep_up;
`endif
    end
    if (go_up || go_dn) begin
      case (state)
        F_YEAR:  if (go_up) inc_nxt[0] = 1'b1; else dec_nxt[0] = 1'b1;
        F_MONTH: if (go_up) inc_nxt[1] = 1'b1; else dec_nxt[1] = 1'b1;
        F_DAY:   if (go_up) inc_nxt[2] = 1'b1; else dec_nxt[2] = 1'b1;
        F_AP:    inc_nxt[3] = 1'b1;
        F_HOUR:  if (go_up) inc_nxt[4] = 1'b1; else dec_nxt[3] = 1'b1;
        F_MIN:   if (go_up) inc_nxt[5] = 1'b1; else dec_nxt[4] = 1'b1;
        F_SEC:   if (go_up) inc_nxt[6] = 1'b1; else dec_nxt[5] = 1'b1;
        default: ;
      endcase
    end
  end

  assign strobe = go_up || go_dn;
  assign entry  = (state_nxt != state);

  // State, registered strobes, idle timeout and blink phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= F_NORMAL;
      inc_q     <= '0;
      dec_q     <= '0;
      tmo_cnt   <= '0;
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else begin
      state <= state_nxt;
      inc_q <= inc_nxt;
      dec_q <= dec_nxt;

      if (entry || mode_p || up_p || down_p || strobe || state_nxt == F_NORMAL)
        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_MS))
        tmo_cnt <= tmo_cnt + 1'b1;

      // Reload on entry or strobe keeps the freshly adjusted value visible.
      if (entry || strobe || state_nxt == F_NORMAL) begin
        blink_q   <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_q   <= ~blink_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

`ifdef WATCH_AUTOREPEAT_EN
  // Auto-repeat timer: armed by an up/down press strobe outside AP, cancelled
  // by release, any new press or any state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_act   <= 1'b0;
      rep_up    <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (entry || state_nxt == F_NORMAL) begin
      rep_act <= 1'b0;
      rep_cnt <= '0;
    end else if (strobe && !rep_fire) begin
      rep_act   <= (state != F_AP);
      rep_up    <= go_up;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_act) begin
      if (!held || up_p || down_p || mode_p) begin
        rep_act <= 1'b0;
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`endif

  assign {i_s, i_m, i_h, i_a, i_d, i_mo, i_y} = inc_q;
  assign {d_s, d_m, d_h, d_d, d_mo, d_y}      = dec_q;
  assign edit  = (state != F_NORMAL);
  assign field = state;
  assign blink = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed and random button actions; a reference
// model predicts each visible event (strobe or field change) with its cycle,
// and a monitor compares every event the DUT shows against that queue.
module tb_watch_set_ctrl;

  localparam int DEB   = 20;
  localparam int TMO   = 10000;
  localparam int BLK   = 250;
  localparam int RDLY  = 500;
  localparam int RRATE = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic i_y, i_mo, i_d, i_a, i_h, i_m, i_s;
  logic d_y, d_mo, d_d, d_h, d_m, d_s;
  logic edit, blink;
  logic [2:0] field;

  watch_set_ctrl dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .i_y(i_y), .i_mo(i_mo), .i_d(i_d), .i_a(i_a), .i_h(i_h), .i_m(i_m), .i_s(i_s),
    .d_y(d_y), .d_mo(d_mo), .d_d(d_d), .d_h(d_h), .d_m(d_m), .d_s(d_s),
    .edit(edit), .field(field), .blink(blink));

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Expected visible event: negedge sample index, tolerance, strobes, field.
  typedef struct {
    int         cnt;
    int         tol;
    logic [12:0] strobes;
    int         fld;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_field = 0;
  int   last_act = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic push(input int cnt, input int tol, input logic [12:0] s, input int f);
    exp_t e;
    e.cnt = cnt; e.tol = tol; e.strobes = s; e.fld = f;
    q.push_back(e);
  endtask

  // Bit layout: 0..6 = i_y,i_mo,i_d,i_a,i_h,i_m,i_s ; 7..12 = d_y,d_mo,d_d,d_h,d_m,d_s
  function automatic logic [12:0] strobe_for(input int f, input bit up);
    logic [12:0] v;
    v = '0;
    if (up || f == 4) v[f-1] = 1'b1;
    else begin
      case (f)
        1: v[7]  = 1'b1;
        2: v[8]  = 1'b1;
        3: v[9]  = 1'b1;
        5: v[10] = 1'b1;
        6: v[11] = 1'b1;
        7: v[12] = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction

  // Monitor: any strobe or field change is an event to match against the queue.
  logic [12:0] mon_s;
  int          mon_f;
  int          prev_field = 0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_s = {d_s, d_m, d_h, d_d, d_mo, d_y, i_s, i_m, i_h, i_a, i_d, i_mo, i_y};
      mon_f = int'(field);
      if (mon_s != '0 || mon_f != prev_field) begin
        if (q.size() == 0) begin
          check("unexpected_event", 1'b0,
                $sformatf("at %0d saw strobes=%h field=%0d, none expected", edge_cnt, mon_s, mon_f));
        end else begin
          mon_e = q.pop_front();
          check("event",
                edge_cnt >= mon_e.cnt - mon_e.tol && edge_cnt <= mon_e.cnt + mon_e.tol &&
                mon_s == mon_e.strobes && mon_f == mon_e.fld &&
                edit == (mon_e.fld != 0) && blink == 1'b1,
                $sformatf("got at=%0d strobes=%h field=%0d edit=%0b blink=%0b, want at=%0d(+-%0d) strobes=%h field=%0d edit=%0b blink=1",
                          edge_cnt, mon_s, mon_f, edit, blink, mon_e.cnt, mon_e.tol,
                          mon_e.strobes, mon_e.fld, mon_e.fld != 0));
        end
      end
      prev_field = mon_f;
    end
  end

  // Drive one button action and predict its visible effect.
  task automatic action(input bit m, input bit u, input bit d, input int hold);
    int n, p, l;
    @(negedge clk);
    n = edge_cnt;
    btn_mode = m; btn_up = u; btn_down = d;
    if (hold >= DEB) begin
      p = n + DEB + 2;
      last_act = p;
      if (m) begin
        m_field = (m_field + 1) % 8;
        push(p + 1, 0, '0, m_field);
      end else if (u && d) begin
      end else if (m_field != 0) begin
        push(p + 1, 0, strobe_for(m_field, u), m_field);
`ifdef WATCH_AUTOREPEAT_EN
        if (m_field != 4) begin
          l = n + hold + DEB + 1;
          for (int t = p + RDLY; t <= l; t += RRATE)
            push(t + 1, 0, strobe_for(m_field, u), m_field);
        end
`endif
      end
    end
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (DEB + 25) @(negedge clk);
  endtask

  task automatic blink_at(input int entry, input int k, input bit exp);
    while (edge_cnt < entry + k + 1) @(negedge clk);
    check("blink_phase", edge_cnt == entry + k + 1 && blink == exp,
          $sformatf("k=%0d got blink=%0b want %0b", k, blink, exp));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int b;
    b = budget;
    while (q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check(name, q.size() == 0, $sformatf("%0d expected events still pending", q.size()));
  endtask

  initial begin
    int kind, h, e;
    bit b;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_field", field == 3'd0, $sformatf("got %0d want 0", field));
    check("reset_edit", edit == 1'b0, $sformatf("got %0b want 0", edit));
    check("reset_blink", blink == 1'b1, $sformatf("got %0b want 1", blink));
    check("reset_strobes",
          {i_y, i_mo, i_d, i_a, i_h, i_m, i_s, d_y, d_mo, d_d, d_h, d_m, d_s} == 13'd0,
          "some strobe high in reset");
    rst = 1'b1;
    mon_en = 1'b1;

    action(1, 0, 0, 30);                   // -> YEAR
    e = last_act;
    blink_at(e, 100, 1'b1);
    blink_at(e, BLK - 1, 1'b1);
    blink_at(e, BLK, 1'b0);
    blink_at(e, 2 * BLK - 1, 1'b0);
    blink_at(e, 2 * BLK, 1'b1);
    action(0, 1, 0, 40);                   // i_y
    action(0, 1, 0, 10);                   // glitch
    action(0, 1, 0, DEB - 1);              // longest glitch
    action(0, 0, 1, 30);                   // d_y
    repeat (3) action(1, 0, 0, 30);        // -> AP
    action(0, 0, 1, 30);                   // i_a
    action(1, 0, 0, 30);                   // -> HOUR
    action(0, 1, 1, 30);                   // discarded
    action(1, 0, 0, 30);                   // -> MIN
    action(0, 1, 0, 1000);                 // i_m (+ repeats if enabled)
    action(1, 0, 0, 30);                   // -> SEC
    action(1, 1, 0, 30);                   // mode wins -> NORMAL
    repeat (8) action(1, 0, 0, 30);        // 1..7, 0
    repeat (6) action(1, 0, 0, 30);        // -> MIN
    push(last_act + TMO + 2, 2, '0, 0);
    m_field = 0;
    wait_drain(TMO + 200, "timeout_return");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      h = $urandom_range(25, 80);
      b = 1'($urandom_range(0, 1));
      case (kind)
        0: action(1, 0, 0, h);
        1: action(0, 1, 0, h);
        2: action(0, 0, 1, h);
        3: action(0, 1, 1, h);
        4: action(1, b, !b, h);
        default: action(b, !b, 1'b0, $urandom_range(1, DEB - 1));
      endcase
    end
    wait_drain(200, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
